mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares one single-port word memory between the instruction-fetch port (IF) and the load/store port (DM) of the core pipeline.
- Sits between the core and the memory model.
- Arbitrates requests, sequences one outstanding memory transaction at a time, and routes each response back to its owner.
- Aborts with an error response on a memory timeout.

Parameters:
- TIMEOUT, 16: max cycles from issue to response before abort; legal range 2..255.
- FAIR_LIMIT, 4: max consecutive DM grants while IF is pending before IF is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  32  fetch byte address
- if_gnt  out  1  fetch request accepted (combinational, IDLE only)
- if_rvalid  out  1  fetch response, 1-cycle pulse
- if_rdata  out  32  fetch data
- if_err  out  1  fetch error, qualified by if_rvalid
- dm_req  in  1  data request; held with the other dm_* inputs until dm_gnt
- dm_we  in  1  1 = store
- dm_be  in  4  store byte enables
- dm_addr  in  32  data byte address
- dm_wdata  in  32  store data
- dm_gnt  out  1  data request accepted (combinational, IDLE only)
- dm_rvalid  out  1  data response pulse; also returned for stores
- dm_rdata  out  32  load data
- dm_err  out  1  data error, qualified by dm_rvalid
- mem_req  out  1  memory request, registered
- mem_we  out  1  registered
- mem_be  out  4  registered
- mem_addr  out  32  registered, word aligned
- mem_wdata  out  32  registered
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  memory response
- mem_rdata  in  32  memory read data
- mem_err  in  1  memory error, qualified by mem_rvalid

Behaviour:
- Reset (async, resetn=0):
  - State = IDLE.
  - All registered outputs = 0, including mem_req, the mem_* fields and the x_rvalid/x_rdata/x_err registers.
  - Fairness and timeout counters = 0.
  - A reset mid-transaction drops mem_req immediately; no response is produced.
- FSM IDLE -> ISSUE -> WAIT -> IDLE. Only one transaction is outstanding at any time.
- IDLE:
  - Owner selection: DM wins if dm_req && !(if_req && streak==FAIR_LIMIT); otherwise IF wins if if_req.
  - The winner's x_gnt=1 this cycle. Its request is registered into mem_* and into the owner register, and the FSM moves to ISSUE.
  - No request: stay in IDLE; both gnt outputs are 0.
- Fetch mapping: mem_we=0, mem_be=4'hF.
- Data mapping: mem_we=dm_we; mem_be=dm_be when dm_we=1, otherwise mem_be=4'hF.
- Address: mem_addr = addr with bits [1:0] forced to 0.
- Fairness streak counter:
  - Increments on a DM grant while if_req=1.
  - Clears on any IF grant, or on a DM grant while if_req=0.
  - Saturates at FAIR_LIMIT.
- ISSUE:
  - mem_req=1 and all mem_* fields are held stable.
  - On mem_gnt: mem_req is 0 from the next cycle and the FSM moves to WAIT.
  - A mem_rvalid in the same cycle as mem_gnt is legal. It completes the transaction directly: ISSUE -> IDLE with a response.
- WAIT: on mem_rvalid, register a response to the owner and return to IDLE.
- Response:
  - owner_rvalid=1 for exactly one cycle, in the cycle after mem_rvalid.
  - owner_rdata = mem_rdata; owner_err = mem_err.
  - The non-owner's rvalid stays 0.
  - x_rdata holds its value between responses.
- Timeout:
  - The counter clears on entry to ISSUE and counts each cycle in ISSUE and WAIT.
  - When it reaches TIMEOUT-1 without a response: mem_req drops, owner gets rvalid=1, err=1, rdata=0 the next cycle, and the FSM returns to IDLE.
  - A mem_rvalid arriving in IDLE is discarded.
- Latency with zero-wait memory (mem_gnt during the first ISSUE cycle, mem_rvalid in WAIT):
  - gnt at cycle 0, mem_req at cycle 1, mem_rvalid at cycle 2, x_rvalid at cycle 3.
  - Next grant is possible at cycle 3, so peak throughput is one transaction per 3 cycles.
- Both requesters asserted in IDLE in the same cycle: exactly one gnt, per the selection rule above.

Decomposition:
- Add to the shared riscv package:
  - arb_state_t enum {ARB_IDLE, ARB_ISSUE, ARB_WAIT}.
  - arb_owner_t enum {OWNER_IF, OWNER_DM}.
  - mem_req_t packed struct {we, be, addr, wdata}.
  - Reuse word_t for the 32-bit fields.
- Sub-module mem_watchdog:
  - Parameter TIMEOUT; inputs clk, resetn, clear, run; output expired.
  - Contains the timeout counter.
- Arbitration, fairness and the FSM stay inline.

Test Plan:
- Reset with if_req=1 -> all outputs 0. Release reset -> if_gnt=1 in IDLE; mem_req=1, mem_addr=0x0000_0000, mem_be=4'hF; zero-wait memory returns 0x0000_0013 -> if_rvalid=1 with if_rdata=0x0000_0013 exactly 3 cycles after if_gnt.
- dm_req and if_req held continuously, FAIR_LIMIT=4 -> grant sequence DM,DM,DM,DM,IF,DM,... After an IF grant, DM wins again.
- Store: dm_we=1, dm_be=4'b0011, dm_addr=0x0000_1006, dm_wdata=0xDEAD_BEEF -> mem_addr=0x0000_1004, mem_be=4'b0011, mem_wdata=0xDEAD_BEEF; dm_rvalid pulses once; if_rvalid stays 0.
- Memory withholds mem_gnt indefinitely, TIMEOUT=16 -> mem_req drops 16 cycles after issue; dm_rvalid=1, dm_err=1, dm_rdata=0; a later stray mem_rvalid is ignored.
- mem_gnt and mem_rvalid in the same cycle, mem_err=1 -> ISSUE->IDLE; owner gets rvalid=1, err=1 on the next cycle.
- resetn asserted in WAIT -> mem_req=0 and state=IDLE immediately. After release, no rvalid pulse appears and a new if_req is granted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IF/DM memory arbiter.
package mem_arbiter_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_IF = 1'b0,
    OWNER_DM = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic       we;
    logic [3:0] be;
    word_t      addr;
    word_t      wdata;
  } mem_req_t;

  localparam logic [3:0] BE_FULL = 4'hF;

  // Memory is word addressed; byte offset bits are dropped.
  function automatic word_t word_align(input word_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Transaction timeout counter: cleared when a transaction is issued,
// counts while one is outstanding, flags expiry at TIMEOUT-1.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // Count outstanding cycles, saturating at the expiry value.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (run && (r_count != LAST)) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign expired = run && (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (IF) and load/store (DM) ports onto one
// single-port memory, one transaction outstanding at a time.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 16,
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_gnt,
  output logic        dm_rvalid,
  output logic [31:0] dm_rdata,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err
);

  localparam logic [3:0] FAIR_MAX = 4'(FAIR_LIMIT);

  arb_state_t r_state;
  arb_owner_t r_owner;
  mem_req_t   r_mem;
  logic       r_mem_req;
  logic [3:0] r_streak;

  logic       r_if_rvalid;
  word_t      r_if_rdata;
  logic       r_if_err;
  logic       r_dm_rvalid;
  word_t      r_dm_rdata;
  logic       r_dm_err;

  logic       w_idle;
  logic       w_fair_block;
  logic       w_dm_win;
  logic       w_if_win;
  logic       w_grant;
  logic       w_busy;
  logic       w_done;
  logic       w_expired;
  logic       w_abort;
  mem_req_t   w_new_req;

  // Grants are only offered in IDLE; reset also masks them so every
  // output is quiet while resetn is low.
  assign w_idle       = resetn && (r_state == ARB_IDLE);
  assign w_fair_block = if_req && (r_streak == FAIR_MAX);
  assign w_dm_win     = w_idle && dm_req && !w_fair_block;
  assign w_if_win     = w_idle && if_req && !w_dm_win;
  assign w_grant      = w_dm_win || w_if_win;

  assign w_busy  = (r_state == ARB_ISSUE) || (r_state == ARB_WAIT);
  assign w_done  = ((r_state == ARB_ISSUE) && mem_gnt && mem_rvalid) ||
                   ((r_state == ARB_WAIT) && mem_rvalid);
  // A real response in the expiry cycle takes precedence over the abort.
  assign w_abort = w_expired && !w_done;

  // Build the memory request for whichever port wins this cycle.
  always_comb begin
    w_new_req = '0;
    if (w_dm_win) begin
      w_new_req.we    = dm_we;
      w_new_req.be    = dm_we ? dm_be : BE_FULL;
      w_new_req.addr  = word_align(dm_addr);
      w_new_req.wdata = dm_wdata;
    end else begin
      w_new_req.we    = 1'b0;
      w_new_req.be    = BE_FULL;
      w_new_req.addr  = word_align(if_addr);
      w_new_req.wdata = '0;
    end
  end

  mem_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (w_grant),
    .run     (w_busy),
    .expired (w_expired)
  );

  // Transaction sequencer: IDLE -> ISSUE -> WAIT -> IDLE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ARB_IDLE;
      r_owner   <= OWNER_IF;
      r_mem     <= '0;
      r_mem_req <= 1'b0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_grant) begin
            r_mem     <= w_new_req;
            r_owner   <= w_dm_win ? OWNER_DM : OWNER_IF;
            r_mem_req <= 1'b1;
            r_state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (w_done || w_abort) begin
            r_mem_req <= 1'b0;
            r_state   <= ARB_IDLE;
          end else if (mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (w_done || w_abort) begin
            r_state <= ARB_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= ARB_IDLE;
        end
      endcase
    end
  end

  // Consecutive DM wins while IF waits; IF is forced through at the limit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_streak <= '0;
    end else if (w_dm_win) begin
      if (!if_req) begin
        r_streak <= '0;
      end else if (r_streak != FAIR_MAX) begin
        r_streak <= r_streak + 4'd1;
      end
    end else if (w_if_win) begin
      r_streak <= '0;
    end
  end

  // Route a completed or aborted transaction back to its owner as a pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_if_err    <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
      r_dm_err    <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      if (w_done || w_abort) begin
        if (r_owner == OWNER_DM) begin
          r_dm_rvalid <= 1'b1;
          r_dm_rdata  <= w_abort ? '0 : mem_rdata;
          r_dm_err    <= w_abort ? 1'b1 : mem_err;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= w_abort ? '0 : mem_rdata;
          r_if_err    <= w_abort ? 1'b1 : mem_err;
        end
      end
    end
  end

  assign if_gnt    = w_if_win;
  assign dm_gnt    = w_dm_win;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_err    = r_if_err;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign dm_err    = r_dm_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem.we;
  assign mem_be    = r_mem.be;
  assign mem_addr  = r_mem.addr;
  assign mem_wdata = r_mem.wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with hand-computed expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        dm_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .TIMEOUT    (16),
    .FAIR_LIMIT (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .dm_req     (dm_req),
    .dm_we      (dm_we),
    .dm_be      (dm_be),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_gnt     (dm_gnt),
    .dm_rvalid  (dm_rvalid),
    .dm_rdata   (dm_rdata),
    .dm_err     (dm_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait transaction starting in an IDLE cycle with requests already
  // driven; returns in the response cycle (3 cycles after the grant).
  task automatic xact(input string tag, input logic [1:0] exp_gnt,
                      input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic exp_we, input logic [31:0] exp_wdata,
                      input logic [31:0] rdata);
    chk({tag, ":gnt"}, {30'd0, if_gnt, dm_gnt}, {30'd0, exp_gnt});
    mem_gnt = 1'b1;
    step();
    chk({tag, ":mem_req"}, {31'd0, mem_req}, 32'd1);
    chk({tag, ":mem_addr"}, mem_addr, exp_addr);
    chk({tag, ":mem_be"}, {28'd0, mem_be}, {28'd0, exp_be});
    chk({tag, ":mem_we"}, {31'd0, mem_we}, {31'd0, exp_we});
    if (exp_we) chk({tag, ":mem_wdata"}, mem_wdata, exp_wdata);
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    mem_err    = 1'b0;
    step();
    mem_rvalid = 1'b0;
    chk({tag, ":rvalid"}, {30'd0, if_rvalid, dm_rvalid}, {30'd0, exp_gnt});
    chk({tag, ":rdata"}, exp_gnt[0] ? dm_rdata : if_rdata, rdata);
  endtask

  logic [1:0] fair_seq [6];

  initial begin
    resetn     = 1'b0;
    if_req     = 1'b1;
    if_addr    = 32'h0000_0000;
    dm_req     = 1'b0;
    dm_we      = 1'b0;
    dm_be      = 4'h0;
    dm_addr    = '0;
    dm_wdata   = '0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_err    = 1'b0;

    // Reset with IF requesting: everything quiet.
    #3;
    chk("rst:if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("rst:dm_gnt", {31'd0, dm_gnt}, 32'd0);
    chk("rst:mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst:mem_be", {28'd0, mem_be}, 32'd0);
    chk("rst:mem_addr", mem_addr, 32'd0);
    chk("rst:mem_wdata", mem_wdata, 32'd0);
    chk("rst:rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    chk("rst:rdata", if_rdata | dm_rdata, 32'd0);
    step();
    step();
    resetn = 1'b1;
    #1;

    // First fetch: response exactly 3 cycles after the grant.
    xact("if0", 2'b10, 32'h0000_0000, 4'hF, 1'b0, 32'd0, 32'h0000_0013);
    chk("if0:err", {31'd0, if_err}, 32'd0);
    if_req = 1'b0;
    step();
    chk("if0:pulse", {31'd0, if_rvalid}, 32'd0);
    chk("if0:hold", if_rdata, 32'h0000_0013);

    // Both held: DM x4, then IF forced, then DM again.
    fair_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    dm_req  = 1'b1;
    dm_we   = 1'b0;
    dm_addr = 32'h0000_0105;
    if_req  = 1'b1;
    if_addr = 32'h0000_0202;
    #1;
    for (int i = 0; i < 6; i++) begin
      xact($sformatf("fair%0d", i), fair_seq[i],
           fair_seq[i][0] ? 32'h0000_0104 : 32'h0000_0200,
           4'hF, 1'b0, 32'd0, 32'h100 + 32'(i));
    end
    dm_req = 1'b0;
    if_req = 1'b0;
    step();

    // Partial store on a misaligned address.
    dm_req   = 1'b1;
    dm_we    = 1'b1;
    dm_be    = 4'b0011;
    dm_addr  = 32'h0000_1006;
    dm_wdata = 32'hDEAD_BEEF;
    #1;
    xact("st", 2'b01, 32'h0000_1004, 4'b0011, 1'b1, 32'hDEAD_BEEF, 32'hA5A5_0001);
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_be    = 4'h0;
    dm_wdata = '0;
    step();
    chk("st:pulse", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

    // Memory never grants: abort after 16 issue cycles.
    dm_req  = 1'b1;
    dm_addr = 32'h0000_2000;
    #1;
    chk("to:gnt", {31'd0, dm_gnt}, 32'd1);
    step();
    dm_req = 1'b0;
    for (int i = 1; i < 16; i++) step();
    chk("to:req_c16", {31'd0, mem_req}, 32'd1);
    step();
    chk("to:req_drop", {31'd0, mem_req}, 32'd0);
    chk("to:rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd1);
    chk("to:err", {31'd0, dm_err}, 32'd1);
    chk("to:rdata", dm_rdata, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0055;
    step();
    mem_rvalid = 1'b0;
    chk("stray:rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    chk("stray:rdata", dm_rdata, 32'd0);
    chk("stray:req", {31'd0, mem_req}, 32'd0);

    // Grant and response in the same ISSUE cycle, with error.
    if_req  = 1'b1;
    if_addr = 32'h0000_3003;
    #1;
    chk("fast:gnt", {31'd0, if_gnt}, 32'd1);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_err    = 1'b1;
    mem_rdata  = 32'h0000_0077;
    step();
    if_req = 1'b0;
    chk("fast:req", {31'd0, mem_req}, 32'd1);
    chk("fast:addr", mem_addr, 32'h0000_3000);
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_err    = 1'b0;
    chk("fast:rvalid", {30'd0, if_rvalid, dm_rvalid}, 32'd2);
    chk("fast:err", {31'd0, if_err}, 32'd1);
    chk("fast:rdata", if_rdata, 32'h0000_0077);
    chk("fast:req_drop", {31'd0, mem_req}, 32'd0);
    if_req  = 1'b1;
    if_addr = 32'h0000_0040;
    #1;
    chk("fast:idle", {31'd0, if_gnt}, 32'd1);

    // Reset while waiting for a response.
    mem_gnt = 1'b1;
    step();
    if_req = 1'b0;
    step();
    mem_gnt = 1'b0;
    dm_req  = 1'b1;
    dm_addr = 32'h0000_0044;
    #1;
    chk("rw:busy", {31'd0, dm_gnt}, 32'd0);
    resetn = 1'b0;
    #1;
    chk("rw:req", {31'd0, mem_req}, 32'd0);
    chk("rw:rdata", if_rdata, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0099;
    step();
    resetn  = 1'b1;
    dm_req  = 1'b0;
    if_req  = 1'b1;
    if_addr = 32'h0000_0080;
    #1;
    chk("rw:regnt", {31'd0, if_gnt}, 32'd1);
    step();
    mem_rvalid = 1'b0;
    if_req     = 1'b0;
    chk("rw:norv", {30'd0, if_rvalid, dm_rvalid}, 32'd0);
    chk("rw:issue", {31'd0, mem_req}, 32'd1);
    chk("rw:addr", mem_addr, 32'h0000_0080);

    // Reset during ISSUE drops mem_req at once.
    resetn = 1'b0;
    #1;
    chk("ri:req", {31'd0, mem_req}, 32'd0);
    step();
    resetn = 1'b1;
    step();
    chk("ri:norv", {30'd0, if_rvalid, dm_rvalid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
